// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Responder end of the instruction-fetch bus. Answers fetch requests from
//   a word-organised on-chip RAM through a fixed-latency response pipeline.
//   Responses are returned strictly in grant order.
//
// Build option:
//   IMEM_GNT_THROTTLE_EN - when defined, an 8-bit Fibonacci LFSR
//   (taps 8,6,5,4, seed 8'hA5) gates the grant low whenever lfsr[1:0]==0.
//
// Ports:
//   clk, rst         - clock (rising edge), synchronous active-high reset
//   instr_req_i      - fetch request
//   instr_gnt_o      - request accepted this cycle (combinational)
//   instr_addr_i     - byte address of the request
//   instr_rvalid_o   - one-cycle response strobe per granted request
//   instr_rdata_o    - response data (0 on error, holds when rvalid=0)
//   instr_err_o      - response error, valid with rvalid
//   load_we_i        - program-load write strobe (wins over fetches)
//   load_addr_i      - program-load word index
//   load_wdata_i     - program-load data
//   outstanding_o    - granted-but-unanswered request count (debug)
//
// Handshake: a transfer happens on every cycle with instr_req_i &
// instr_gnt_o. Each transfer produces exactly one instr_rvalid_o pulse
// LATENCY cycles later; there is no response backpressure.
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned NUM_REQS  = 2,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_req_i,
  output logic          instr_gnt_o,
  input  logic [31:0]   instr_addr_i,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  output logic          instr_rvalid_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_wdata_i,
  output logic [2:0]    outstanding_o
);

  // 33 bits so that a 2^30-word RAM still has a representable byte size.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [2:0]  MAX_OUT   = 3'(NUM_REQS);

  // Program RAM; not reset, so an image survives a fetch-side reset.
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Address decode. The modulo subtraction folds addresses below BASE_ADDR
  // up into the high range, so a single upper-bound compare catches both.
  logic [31:0]   addr_offset;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;

  assign addr_offset = instr_addr_i - BASE_ADDR;
  assign req_err     = !({1'b0, addr_offset} < MEM_BYTES);
  assign word_idx    = addr_offset[AW+1:2];
  assign rd_word     = mem[word_idx];

  // Response pipeline: stage LATENCY-1 is the output register.
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];
  logic [LATENCY-1:0] in_valid, in_err;
  logic [31:0]        in_data [LATENCY];

  logic       retiring;
  logic       slot_free;
  logic       throttle_ok;
  logic       xfer;
  logic [2:0] cnt_q, cnt_d;

  assign retiring = valid_q[LATENCY-1];

  // A full counter can still accept when a response leaves this cycle.
  assign slot_free = (cnt_q < MAX_OUT) || retiring;

  assign instr_gnt_o = instr_req_i & !rst & !load_we_i & slot_free & throttle_ok;
  assign xfer        = instr_gnt_o;

`ifdef IMEM_GNT_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign throttle_ok = (lfsr_q[1:0] != 2'b00);
`else
  assign throttle_ok = 1'b1;
`endif

  // Stage inputs: stage 0 takes the RAM read at the grant edge, later
  // stages take their predecessor.
  always_comb begin
    in_valid    = '0;
    in_err      = '0;
    in_valid[0] = xfer;
    in_err[0]   = xfer & req_err;
    in_data[0]  = req_err ? 32'h0 : rd_word;
    for (int i = 1; i < LATENCY; i++) begin
      in_valid[i] = valid_q[i-1];
      in_err[i]   = err_q[i-1];
      in_data[i]  = data_q[i-1];
    end
  end

  // Data only moves with a valid entry so the output holds its last value;
  // err is forced low for empty slots.
  always_comb begin
    valid_d = in_valid;
    err_d   = in_valid & in_err;
    for (int i = 0; i < LATENCY; i++) begin
      data_d[i] = in_valid[i] ? in_data[i] : data_q[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({xfer, retiring})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= 32'h0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign instr_rvalid_o = valid_q[LATENCY-1];
  assign instr_err_o    = err_q[LATENCY-1];
  assign instr_rdata_o  = data_q[LATENCY-1];
  assign outstanding_o  = cnt_q;

endmodule
